// File: rtl/tx_lp_sequencer.sv
// C-PHY slave TX LP sequencer: HS-burst entry/exit and bus turnaround over one shared TX timer.
// Optional watchdog fault path compiled in with `define TXSEQ_WDOG_EN.
module tx_lp_sequencer #(
  parameter int unsigned WDOG_CYC = 64,
  parameter int unsigned STATE_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hs_req,
  input  logic               hs_done,
  input  logic               ta_req,
  input  logic               timeout,
  output logic               timer_en,
  output logic               timer_seed,
  output logic [2:0]         lp_tx,
  output logic               lp_oe,
  output logic               hs_tx_en,
  output logic               ta_done,
  output logic               busy,
  output logic [STATE_W-1:0] state_o,
  output logic               wdog_err
);

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_HS_RQST  = 3'd1,
    ST_HS_PREP  = 3'd2,
    ST_HS_BURST = 3'd3,
    ST_HS_EXIT  = 3'd4,
    ST_TA_GO    = 3'd5,
    ST_TA_REL   = 3'd6,
    ST_FAULT    = 3'd7
  } state_e;

  function automatic logic is_timed(input state_e s);
    return (s == ST_HS_RQST) || (s == ST_HS_PREP) || (s == ST_HS_EXIT) || (s == ST_TA_GO);
  endfunction

  state_e     state_q, state_d;
  logic       timer_en_q, timer_en_d;
  logic       timer_seed_q, timer_seed_d;
  logic [2:0] lp_tx_q, lp_tx_d;
  logic       lp_oe_q, lp_oe_d;
  logic       hs_tx_en_q, hs_tx_en_d;
  logic       ta_done_q, ta_done_d;
  logic       busy_q, busy_d;
  logic       ta_pend_q, ta_pend_d;
  logic       entry;

`ifdef TXSEQ_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              wdog_err_q, wdog_err_d;
  logic              wdog_hit;

  assign wdog_hit = is_timed(state_q) && timer_en_q && !timeout &&
                    (wdog_q == WDOG_W'(WDOG_CYC - 1));
`endif

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (hs_req)                    state_d = ST_HS_RQST;
        else if (ta_req || ta_pend_q)  state_d = ST_TA_GO;
      end
      ST_HS_RQST:  if (timeout) state_d = ST_HS_PREP;
      ST_HS_PREP:  if (timeout) state_d = ST_HS_BURST;
      ST_HS_BURST: if (hs_done) state_d = ST_HS_EXIT;
      ST_HS_EXIT:  if (timeout) state_d = ST_STOP;
      ST_TA_GO:    if (timeout) state_d = ST_TA_REL;
      ST_TA_REL:   state_d = ST_STOP;
      ST_FAULT:    if (!hs_req) state_d = ST_STOP;
      default:     state_d = ST_STOP;
    endcase
`ifdef TXSEQ_WDOG_EN
    if (wdog_hit) state_d = ST_FAULT;
`endif
  end

  assign entry = (state_d != state_q);

  // Outputs decoded from the next state so they register alongside it.
  // The entry cycle of a timed state holds timer_en low so the timer reloads.
  always_comb begin
    lp_tx_d      = 3'b111;
    lp_oe_d      = 1'b1;
    hs_tx_en_d   = 1'b0;
    timer_seed_d = (state_d == ST_TA_GO);
    timer_en_d   = is_timed(state_d) && !entry;
    ta_done_d    = (state_d == ST_TA_REL);
    busy_d       = (state_d != ST_STOP);
    case (state_d)
      ST_HS_RQST:  lp_tx_d = 3'b001;
      ST_HS_PREP:  lp_tx_d = 3'b000;
      ST_HS_BURST: begin
        lp_tx_d    = 3'b000;
        lp_oe_d    = 1'b0;
        hs_tx_en_d = 1'b1;
      end
      ST_TA_GO:    lp_tx_d = 3'b000;
      ST_TA_REL: begin
        lp_tx_d = 3'b000;
        lp_oe_d = 1'b0;
      end
      default:     lp_tx_d = 3'b111;
    endcase
  end

  // A turnaround request that cannot start now is remembered; repeats collapse.
  always_comb begin
    ta_pend_d = ta_pend_q;
    if (state_q == ST_TA_REL)                           ta_pend_d = 1'b0;
    if ((state_q == ST_FAULT) && (state_d == ST_STOP))  ta_pend_d = 1'b0;
    if (ta_req && !((state_q == ST_STOP) && !hs_req))   ta_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STOP;
      timer_en_q   <= 1'b0;
      timer_seed_q <= 1'b0;
      lp_tx_q      <= 3'b111;
      lp_oe_q      <= 1'b1;
      hs_tx_en_q   <= 1'b0;
      ta_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      ta_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_en_q   <= timer_en_d;
      timer_seed_q <= timer_seed_d;
      lp_tx_q      <= lp_tx_d;
      lp_oe_q      <= lp_oe_d;
      hs_tx_en_q   <= hs_tx_en_d;
      ta_done_q    <= ta_done_d;
      busy_q       <= busy_d;
      ta_pend_q    <= ta_pend_d;
    end
  end

`ifdef TXSEQ_WDOG_EN
  // Counts enabled timer cycles within one state visit.
  always_comb begin
    wdog_d = wdog_q;
    if (entry)           wdog_d = '0;
    else if (timer_en_q) wdog_d = wdog_q + WDOG_W'(1);
    wdog_err_d = wdog_err_q | (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign timer_en   = timer_en_q;
  assign timer_seed = timer_seed_q;
  assign lp_tx      = lp_tx_q;
  assign lp_oe      = lp_oe_q;
  assign hs_tx_en   = hs_tx_en_q;
  assign ta_done    = ta_done_q;
  assign busy       = busy_q;
  assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_tx_lp_sequencer.sv
// Randomized + directed bench for tx_lp_sequencer; reference model works from dwell lengths
// (N+2 cycles per timed state) rather than from the timer handshake.
module tb_tx_lp_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs_req = 1'b0, hs_done = 1'b0, ta_req = 1'b0;
  logic       timeout;
  logic       timer_en, timer_seed, lp_oe, hs_tx_en, ta_done, busy, wdog_err;
  logic [2:0] lp_tx, state_o;

  tx_lp_sequencer #(.WDOG_CYC(64), .STATE_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .hs_req(hs_req), .hs_done(hs_done), .ta_req(ta_req),
    .timeout(timeout), .timer_en(timer_en), .timer_seed(timer_seed), .lp_tx(lp_tx),
    .lp_oe(lp_oe), .hs_tx_en(hs_tx_en), .ta_done(ta_done), .busy(busy),
    .state_o(state_o), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b1;

  // Shared TX timer: counts enabled cycles, registered timeout after tmr_n of them.
  int   tmr_n = 14;
  int   tcnt;
  logic to_q;
  logic stray = 1'b0;
  logic to_mask = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 0; to_q <= 1'b0;
    end else if (timer_en) begin
      tcnt <= tcnt + 1; to_q <= (tcnt == tmr_n - 1);
    end else begin
      tcnt <= 0; to_q <= 1'b0;
    end
  end
  assign timeout = (to_q & ~to_mask) | stray;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state id, cycles spent in it, pending turnaround.
  int m_st = 0, m_cyc = 0;
  bit m_pend = 1'b0;

  function automatic bit timed(input int s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 5);
  endfunction

  function automatic logic [4:0] lp_exp(input int s); // {lp_tx, lp_oe, hs_tx_en}
    case (s)
      1:       return 5'b001_1_0;
      2:       return 5'b000_1_0;
      3:       return 5'b000_0_1;
      5:       return 5'b000_1_0;
      6:       return 5'b000_0_0;
      default: return 5'b111_1_0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_pend = 1'b0;
  endtask

  task automatic check_outs();
    logic [4:0] e;
    e = lp_exp(m_st);
    chk("state", state_o, m_st);
    chk("lp_tx", lp_tx, e[4:2]);
    chk("lp_oe", lp_oe, e[1]);
    chk("hs_tx_en", hs_tx_en, e[0]);
    chk("timer_en", timer_en, timed(m_st) && (m_cyc != 0));
    chk("timer_seed", timer_seed, m_st == 5);
    chk("ta_done", ta_done, m_st == 6);
    chk("busy", busy, m_st != 0);
    chk("wdog_err", wdog_err, 0);
  endtask

  // Apply inputs at negedge, clock once, check at the following negedge.
  task automatic step(input logic hs, input logic ta, input logic dn, input logic sx);
    int nst;
    hs_req = hs; ta_req = ta; hs_done = dn; stray = sx && !timed(m_st);
    nst = m_st;
    case (m_st)
      0: if (hs) nst = 1; else if (ta || m_pend) nst = 5;
      1: if (m_cyc == tmr_n + 1) nst = 2;
      2: if (m_cyc == tmr_n + 1) nst = 3;
      3: if (dn) nst = 4;
      4: if (m_cyc == tmr_n + 1) nst = 0;
      5: if (m_cyc == tmr_n + 1) nst = 6;
      6: nst = 0;
      default: nst = 0;
    endcase
    if (ta && !(m_st == 0 && !hs)) m_pend = 1'b1;
    else if (m_st == 6)            m_pend = 1'b0;
    @(posedge clk);
    m_cyc = (nst == m_st) ? m_cyc + 1 : 0;
    m_st  = nst;
    @(negedge clk);
    if (chk_on) check_outs();
  endtask

  task automatic dwell(input int st, input logic hs, output int d);
    d = 0;
    while (state_o == st[2:0] && d < 200) begin
      d++;
      step(hs, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int d, cnt;
    // Reset state
    repeat (3) @(negedge clk);
    model_reset();
    check_outs();
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // HS entry with N=14: 16-cycle dwell in RQST and PREP
    tmr_n = 14;
    step(1, 0, 0, 0);
    dwell(1, 1'b1, d); chk("rqst_dwell", d, 16);
    dwell(2, 1'b1, d); chk("prep_dwell", d, 16);
    chk("in_burst", state_o, 3);
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("burst_hold", hs_tx_en, 1);
    step(0, 0, 1, 0);
    dwell(4, 1'b0, d); chk("exit_dwell", d, 16);
    chk("back_stop", state_o, 0);

    // Async reset mid-PREP
    step(1, 0, 0, 0);
    while (state_o != 3'd2 && d < 400) begin d++; step(1, 0, 0, 0); end
    repeat (4) step(1, 0, 0, 0);
    rst_n = 1'b0; hs_req = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Turnaround with N=29
    tmr_n = 29;
    step(0, 1, 0, 0);
    dwell(5, 1'b0, d); chk("tago_dwell", d, 31);
    chk("ta_rel", state_o, 6);
    chk("ta_rel_oe", lp_oe, 0);
    step(0, 0, 0, 0);
    chk("ta_stop", state_o, 0);

    // Simultaneous requests: HS first, then one turnaround for many pulses
    tmr_n = 5;
    step(1, 1, 0, 0);
    d = 0;
    while (state_o != 3'd3 && d < 100) begin d++; step(1, 0, 0, 0); end
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    cnt = 0;
    repeat (60) begin
      step(0, 0, 0, 0);
      if (ta_done) cnt++;
    end
    chk("ta_once", cnt, 1);

    // Randomized traffic
    begin
      logic hs;
      hs = 1'b0;
      repeat (3000) begin
        if (m_st == 0 && $urandom_range(0, 7) == 0) tmr_n = $urandom_range(1, 20);
        if ($urandom_range(0, 39) == 0) hs = ~hs;
        step(hs, ($urandom_range(0, 24) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 5) == 0));
      end
    end

`ifdef TXSEQ_WDOG_EN
    // Stuck timer: watchdog trips after 64 enabled cycles
    chk_on = 1'b0;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    to_mask = 1'b1;
    step(1, 0, 0, 0);
    dwell(1, 1'b1, d); chk("wdog_dwell", d, 65);
    chk("fault_state", state_o, 7);
    chk("fault_err", wdog_err, 1);
    chk("fault_lp", lp_tx, 3'b111);
    step(0, 0, 0, 0);
    chk("fault_exit", state_o, 0);
    chk("err_sticky", wdog_err, 1);
    to_mask = 1'b0;
    rst_n = 1'b0; #1;
    chk("err_reset", wdog_err, 0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_lp_sequencer.md
Name: tx_lp_sequencer

Overview:
Slave-side C-PHY transmit LP sequencer. It drives the LP line states for HS-burst entry and exit and for bus turnaround. One shared TX timer (seed 0 = LP/Prepare interval, seed 1 = TA-Go interval) times every interval through a timer_en/timer_seed/timeout handshake. It sits between the link-layer request logic and the lane driver/timer pair.

Parameters:
WDOG_CYC, 64, max cycles any timed state may wait for timeout before fault (only with TXSEQ_WDOG_EN)
STATE_W, 3, width of state_o

Ports:
clk  in  1  system clock
rst_n  in  1  reset
hs_req  in  1  level; request HS burst
hs_done  in  1  1-cycle pulse from HS serializer: last symbol sent
ta_req  in  1  1-cycle pulse; request bus turnaround
timeout  in  1  registered timeout pulse from shared timer
timer_en  out  1  timer enable, registered
timer_seed  out  1  0 = LP/Prepare interval, 1 = TA-Go interval, registered
lp_tx  out  3  LP levels on wires A,B,C
lp_oe  out  1  LP driver enable
hs_tx_en  out  1  HS driver/serializer enable
ta_done  out  1  1-cycle pulse: turnaround released
busy  out  1  high in any state other than STOP
state_o  out  STATE_W  current state encoding
wdog_err  out  1  sticky watchdog fault (0 when feature compiled out)

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock. Reset forces state STOP immediately, including mid-operation.
- Reset output values: lp_tx=111, lp_oe=1, hs_tx_en=0, timer_en=0, timer_seed=0, ta_done=0, busy=0, wdog_err=0. The ta_pending flag clears.
- Encodings and outputs per state (lp_tx/lp_oe/hs_tx_en):
  - STOP=0: 111/1/0.
  - HS_RQST=1: 001/1/0, timed, seed 0.
  - HS_PREP=2: 000/1/0, timed, seed 0.
  - HS_BURST=3: 000/0/1, untimed.
  - HS_EXIT=4: 111/1/0, timed, seed 0.
  - TA_GO=5: 000/1/0, timed, seed 1.
  - TA_REL=6: 000/0/0, single cycle.
  - FAULT=7: 111/1/0.
- All outputs are registered and change on the same edge as the state.
- Transitions:
  - STOP: hs_req=1 -> HS_RQST. Otherwise (ta_req | ta_pending) -> TA_GO. hs_req has priority on the same cycle.
  - HS_RQST -> HS_PREP on timeout.
  - HS_PREP -> HS_BURST on timeout.
  - HS_BURST -> HS_EXIT on hs_done. hs_req deassertion alone does not end the burst.
  - HS_EXIT -> STOP on timeout.
  - TA_GO -> TA_REL on timeout.
  - TA_REL -> STOP unconditionally; ta_done=1 for exactly this cycle; ta_pending clears.
- ta_req while busy, or while losing to hs_req, sets ta_pending. ta_pending is serviced from STOP when hs_req=0. Multiple pulses collapse into one.
- Timer handshake:
  - On entry to any timed state, timer_en=0 for exactly one reload cycle. timer_en=1 from the next cycle until the cycle after timeout is sampled.
  - timer_seed is valid from the entry cycle and stable for the whole state.
  - Back-to-back timed states always get the reload cycle, so the timer restarts its count.
  - With the timer programmed for N cycles, dwell in each timed state = N+2 cycles: N=14 gives 16, N=29 gives 31.
- timeout is ignored in untimed states. hs_done is ignored outside HS_BURST.
- busy = (state != STOP).

Optional Feature:
TXSEQ_WDOG_EN
- Defined:
  - A watchdog counter clears on every state entry and counts while timer_en=1.
  - If it reaches WDOG_CYC without timeout, the next state is FAULT. wdog_err sets sticky.
  - FAULT exits to STOP once hs_req=0; ta_pending clears. wdog_err clears only by reset.
- Undefined: no counter, FAULT unreachable, wdog_err tied to 0.

Test Plan:
- Reset with hs_req=0 -> lp_tx=111, lp_oe=1, timer_en=0, busy=0. Assert rst_n low mid-HS_PREP -> STOP values in the same cycle, without waiting for clk.
- hs_req=1 with timer N=14 -> HS_RQST for 16 cycles (lp_tx=001), then HS_PREP for 16 cycles (lp_tx=000), then HS_BURST with hs_tx_en=1, lp_oe=0. Check timer_en low for exactly 1 cycle at each entry.
- In HS_BURST: inject stray timeout -> no change. Then pulse hs_done -> HS_EXIT, lp_tx=111, timer_seed=0, 16 cycles, then STOP.
- ta_req pulse in STOP with timer N=29 -> TA_GO, timer_seed=1, 31 cycles, then TA_REL with lp_oe=0 and ta_done high for 1 cycle, then STOP.
- ta_req and hs_req on the same cycle -> HS sequence first. After HS_EXIT completes, TA_GO runs with no new request. Three ta_req pulses during the burst -> exactly one turnaround.
- Watchdog build, WDOG_CYC=64, timer output forced 0 in HS_RQST -> after 64 enabled cycles, FAULT and wdog_err=1. Drop hs_req -> STOP; wdog_err stays 1 until reset.
